div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 8 +
 rtl/div_ctrl_div_step.sv | 16 +
 rtl/div_ctrl.sv | 77 +++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared FSM encoding, datapath width and operand-magnitude helper for the divider.
package div_ctrl_pkg;
  localparam int DIV_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic s);
    return (s && v[DIV_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_ctrl_div_step.sv
// div_step: one combinational restoring shift-subtract iteration on unsigned magnitudes.
module div_step import div_ctrl_pkg::*; (
  input  logic [DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] dvs_i,
  output logic [DIV_W-1:0] rem_o,
  output logic [DIV_W-1:0] quo_o
);
  logic [DIV_W:0] t;
  logic [DIV_W:0] diff;
  assign t = {rem_i, quo_i[DIV_W-1]};
  // t never exceeds 2*dvs-1, so bit DIV_W of diff is purely the borrow
  assign diff = t - {1'b0, dvs_i};
  assign rem_o = diff[DIV_W] ? t[DIV_W-1:0] : diff[DIV_W-1:0];
  assign quo_o = {quo_i[DIV_W-2:0], ~diff[DIV_W]};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 34-cycle multi-cycle signed/unsigned divider controller producing {HI=remainder, LO=quotient}.
module div_ctrl import div_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [DIV_W-1:0]     a,
  input  logic [DIV_W-1:0]     b,
  input  logic                 cancel,
  input  logic                 pipe_stall,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*DIV_W-1:0]   result
);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_n, quo_n;
  logic negq_q, negq_d, negr_q, negr_d;
  logic [2*DIV_W-1:0] result_q, result_d;
  div_step u_step (.rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    result_d = result_q;
    if (cancel) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start) begin
      state_d = RUN;
      cnt_d = '0;
      rem_d = '0;
      quo_d = mag(a, signed_div);
      dvs_d = mag(b, signed_div);
      negq_d = signed_div & (a[DIV_W-1] ^ b[DIV_W-1]);
      negr_d = signed_div & a[DIV_W-1];
    end else if (state_q == RUN) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q + 6'd1;
      // a zero divisor keeps the all-ones quotient unnegated in signed mode
      if (cnt_q == 6'(DIV_W - 1)) begin
        state_d = DONE;
        result_d = {negr_q ? -rem_n : rem_n, (negq_q && dvs_q != '0) ? -quo_n : quo_n};
      end
    end else if (state_q == DONE && !pipe_stall) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      result_q <= result_d;
    end
  end
  assign stall_div = (state_q == IDLE && start && !cancel) || state_q == RUN;
  assign ready = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random divides checked against an arithmetic reference model.
module tb_div_ctrl;
  logic clk, rst, start, signed_div, cancel, pipe_stall, stall_div, ready;
  logic [31:0] a, b;
  logic [63:0] result, exp_res;
  int total, bad;

  div_ctrl dut (.clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
                .cancel(cancel), .pipe_stall(pipe_stall), .stall_div(stall_div), .ready(ready),
                .result(result));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sd, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!sd) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input logic sd, input logic [31:0] x, input logic [31:0] y,
                        input bit hold, input int ps);
    int cyc, stalls;
    cyc = 0;
    stalls = 0;
    start = 1'b1;
    signed_div = sd;
    a = x;
    b = y;
    exp_res = model(sd, x, y);
    #1;
    while (!ready && cyc < 100) begin
      if (stall_div) stalls++;
      tick();
      if (!hold) start = 1'b0;
      a = $urandom;
      b = $urandom;
      signed_div = 1'($urandom);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("stall_cycles", 64'(stalls), 64'd33);
    chk("stall_in_done", 64'(stall_div), 64'd0);
    chk("result", result, exp_res);
    pipe_stall = ps > 0;
    for (int k = 0; k < ps; k++) begin
      tick();
      chk("ready_held", 64'(ready), 64'd1);
      chk("result_held", result, exp_res);
    end
    pipe_stall = 1'b0;
    tick();
    chk("ready_after_done", 64'(ready), 64'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    int hits;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (ready || stall_div) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    cancel = 1'b0;
    pipe_stall = 1'b0;
    a = '0;
    b = '0;
    exp_res = '0;
    #12;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_stall", 64'(stall_div), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 1'b0, 0);
    chk("u100_7", result, {32'd2, 32'd14});
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    chk("s_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("s_min_m1", result, {32'h0, 32'h8000_0000});
    do_div(1'b0, 32'h1234_5678, 32'd0, 1'b0, 0);
    chk("u_div0", result, {32'h1234_5678, 32'hFFFF_FFFF});
    do_div(1'b1, 32'hF000_0001, 32'd0, 1'b0, 0);
    chk("s_div0", result, {32'hF000_0001, 32'hFFFF_FFFF});

    for (int i = 0; i < 8; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : ((i % 3 == 1) ? -32'($urandom_range(1, 9)) : $urandom);
      do_div(1'($urandom), x, y, 1'b0, 0);
    end

    // pipe_stall holds DONE with start held; start is then re-accepted back to back
    do_div(1'b0, 32'd1000, 32'd9, 1'b1, 3);
    chk("b2b_accept_stall", 64'(stall_div), 64'd1);
    do_div(1'b1, 32'hFFFF_FC18, 32'd9, 1'b0, 0);

    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd55;
    b = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("run_stall", 64'(stall_div), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    #1;
    chk("cancel_stall", 64'(stall_div), 64'd0);
    chk("cancel_ready", 64'(ready), 64'd0);
    chk("cancel_result", result, exp_res);
    quiet("cancel_quiet", 40);
    chk("cancel_result_late", result, exp_res);

    start = 1'b1;
    cancel = 1'b1;
    #1;
    chk("start_cancel_stall", 64'(stall_div), 64'd0);
    tick();
    start = 1'b0;
    cancel = 1'b0;
    #1;
    chk("start_cancel_idle", 64'(stall_div), 64'd0);
    quiet("start_cancel_quiet", 36);

    start = 1'b1;
    a = 32'd77;
    b = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall_div), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_result", result, 64'd0);
    #3;
    rst = 1'b0;
    tick();
    chk("post_rst_stall", 64'(stall_div), 64'd0);
    quiet("post_rst_quiet", 40);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
